// File: rtl/shift_sub_divider_if.sv
// Handshake and operand/result bundle for shift_sub_divider.
// DIV_SELFCHECK_EN adds the check_err result flag.
interface shift_sub_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;
`ifdef DIV_SELFCHECK_EN
  logic          check_err;

  modport master (output start, dividend, divisor,
                  input  quotient, remainder, busy, done, div_by_zero, check_err);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, busy, done, div_by_zero, check_err);
`else
  modport master (output start, dividend, divisor,
                  input  quotient, remainder, busy, done, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, busy, done, div_by_zero);
`endif
endinterface

// File: rtl/shift_sub_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIV_SELFCHECK_EN to add a Q*D+R == dividend consistency check (check_err).
module shift_sub_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic                clk,
  input  logic                rst,
  shift_sub_divider_if.slave  bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  logic [DW-1:0] q;
  logic [VW-1:0] d;
  // A restored remainder is always < D, so VW bits suffice between steps;
  // the extra bit only exists in the shifted trial value.
  logic [VW-1:0] r;
  logic [CW-1:0] cnt;
  logic          zf;

  logic [VW:0]   r_sh;
  logic [VW:0]   r_sub;
  logic          ge;

  assign r_sh  = {r, q[DW-1]};
  assign ge    = (r_sh >= {1'b0, d});
  assign r_sub = r_sh - {1'b0, d};

`ifdef DIV_SELFCHECK_EN
  logic [DW-1:0]    dvd;
  logic [DW+VW-1:0] recon;
  logic             chk_bad;

  assign recon   = (DW+VW)'(q) * (DW+VW)'(d) + (DW+VW)'(r);
  assign chk_bad = (recon != (DW+VW)'(dvd)) || (r >= d);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      q               <= '0;
      d               <= '0;
      r               <= '0;
      cnt             <= '0;
      zf              <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SELFCHECK_EN
      dvd             <= '0;
      bus.check_err   <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            q        <= bus.dividend;
            d        <= bus.divisor;
            r        <= '0;
            cnt      <= CW'(DW-1);
            zf       <= (bus.divisor == '0);
            bus.busy <= 1'b1;
            state    <= (bus.divisor != '0) ? RUN : FINISH;
`ifdef DIV_SELFCHECK_EN
            dvd      <= bus.dividend;
`endif
          end
        end
        RUN: begin
          r <= ge ? r_sub[VW-1:0] : r_sh[VW-1:0];
          q <= {q[DW-2:0], ge};
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          // Q still holds the untouched dividend when the divisor was zero.
          bus.quotient    <= zf ? '1 : q;
          bus.remainder   <= zf ? q[VW-1:0] : r;
          bus.div_by_zero <= zf;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
`ifdef DIV_SELFCHECK_EN
          bus.check_err   <= !zf && chk_bad;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized self-checking bench for shift_sub_divider against an arithmetic model.
module tb_shift_sub_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_sub_divider_if #(.DW(DW), .VW(VW)) bus ();
  shift_sub_divider #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 gives all-ones / low dividend bits.
  task automatic ref_div(input int a, input int b, output int eq, output int er,
                         output int ez, output int lat);
    if (b == 0) begin
      eq = (1 << DW) - 1; er = a % (1 << VW); ez = 1; lat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 0; lat = DW + 1;
    end
  endtask

  // Issues a/b at the next edge; optionally pokes a stray start at cycle 'intr'.
  task automatic run_op(input string tag, input int a, input int b, input int intr);
    int n, eq, er, ez, lat;
    bit busy_ok;
    ref_div(a, b, eq, er, ez, lat);
    bus.start = 1'b1; bus.dividend = DW'(a); bus.divisor = VW'(b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_ok = bus.busy;
    n = 0;
    while (n < 40) begin
      if (n == intr) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
    chk({tag, ".quotient"}, 64'(bus.quotient), 64'(eq));
    chk({tag, ".remainder"}, 64'(bus.remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(ez));
`ifdef DIV_SELFCHECK_EN
    chk({tag, ".check_err"}, 64'(bus.check_err), 64'd0);
`endif
  endtask

  initial begin
    int a, b, n, nrand;
    bit saw_done;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.quotient", 64'(bus.quotient), 64'd0);
    chk("rst.remainder", 64'(bus.remainder), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("d200_7", 200, 7, -1);
    run_op("d255_1", 255, 1, -1);
    run_op("d13_15", 13, 15, -1);     // issued in the done cycle of the previous op
    run_op("d37_0", 37, 0, -1);
    run_op("d100_10", 100, 10, -1);
    run_op("ignore", 200, 7, 3);

    // Abort mid-run with reset: outputs clear and no done follows.
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.quotient", 64'(bus.quotient), 64'd0);
    chk("abort.remainder", 64'(bus.remainder), 64'd0);
    chk("abort.busy", 64'(bus.busy), 64'd0);
    chk("abort.dbz", 64'(bus.div_by_zero), 64'd0);
    saw_done = bus.done;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort.no_done", 64'(saw_done), 64'd0);
    run_op("d9_2", 9, 2, -1);

`ifdef DIV_SELFCHECK_EN
    nrand = 1000;
`else
    nrand = 300;
`endif
    for (int i = 0; i < nrand; i++) begin
      a = int'($urandom_range(0, (1 << DW) - 1));
`ifdef DIV_SELFCHECK_EN
      b = int'($urandom_range(1, (1 << VW) - 1));
`else
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, (1 << VW) - 1));
`endif
      run_op("rand", a, b, -1);
    end

`ifdef DIV_SELFCHECK_EN
    begin
      logic [VW-1:0] bad_r;
      bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (DW) @(posedge clk);
      #1;
      bad_r = dut.r ^ 1'b1;
      force dut.r = bad_r;
      @(posedge clk); #1;
      release dut.r;
      chk("flip.done", 64'(bus.done), 64'd1);
      chk("flip.check_err", 64'(bus.check_err), 64'd1);
      @(posedge clk); #1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Iterative restoring divider, unsigned. The multicycle inverse of the team's combinational 4x4 multiplier.
- Takes a DW-bit dividend and a VW-bit divisor. Produces quotient and remainder, one quotient bit per clock, MSB first.
- Sits beside the multiplier in the arithmetic datapath.
- Uses a start/busy/done handshake so control logic can issue a divide and wait for the result.

Parameters:
- DW, 8, dividend and quotient width (>=2).
- VW, 4, divisor and remainder width (>=2, <=DW).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- dividend  input  DW  unsigned dividend; sampled when start is accepted.
- divisor  input  VW  unsigned divisor; sampled when start is accepted.
- quotient  output  DW  registered quotient of the last completed operation.
- remainder  output  VW  registered remainder of the last completed operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when quotient/remainder update.
- div_by_zero  output  1  registered flag; valid with done, held until the next done.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - quotient, remainder, busy, done, div_by_zero all reset to 0.
  - Internal registers are cleared.
  - Reset overrides every other input, including mid-operation. No result is produced for an aborted operation.
- States: IDLE, RUN, FINISH.
- IDLE:
  - busy=0.
  - start=1 latches dividend into shift register Q and divisor into register D, and clears the partial remainder R (VW+1 bits).
  - Count loads DW-1.
  - Next state: RUN if divisor != 0, else FINISH with the zero flag set.
- RUN (busy=1), each cycle:
  - R' = {R[VW-1:0], Q[DW-1]}; Q shifts left by one.
  - If R' >= {1'b0, D}: R = R' - D and Q[0] = 1. Else R = R' and Q[0] = 0.
  - Compare and subtract use VW+1 bits. No overflow is possible.
  - When count reaches 0, next state is FINISH; otherwise count decrements.
- FINISH (busy=1, one cycle):
  - Registers quotient=Q, remainder=R[VW-1:0], div_by_zero=zero flag.
  - done pulses on the following cycle.
  - Returns to IDLE.
- Latency:
  - Start accepted at edge k: done is high in the cycle after edge k+DW+1, and results are valid in that same cycle.
  - Divide by zero: done is high after edge k+1.
- Divide by zero result: quotient = all ones, remainder = dividend[VW-1:0], div_by_zero = 1.
- start while busy=1 is ignored; operands are not re-sampled.
- start is accepted in the same cycle done is high, because busy is already 0. A back-to-back operation begins immediately.
- Outputs hold their last values until the next done. Intermediate Q and R are never visible on the ports.
- No exceptional handling is needed for divisor > dividend: the quotient is 0 and the remainder equals the dividend. Valid only when dividend < 2^VW.

Optional Feature:
- Macro DIV_SELFCHECK_EN.
- When defined:
  - Adds output check_err (1 bit), reset 0.
  - In FINISH for non-zero divisors, recomputes Q*D + R using a multiplier, compares it against the latched dividend, and checks R < D.
  - Registers check_err=1 alongside done on any mismatch; otherwise 0.
  - For the divide-by-zero case, check_err=0.
- When undefined: no check_err port, no multiplier, behaviour otherwise identical.

Test Plan:
- DW=8, VW=4, reset then start with 200/7 -> done exactly 9 cycles after the start edge; quotient=28, remainder=4, div_by_zero=0, busy high during the 8 RUN cycles plus FINISH.
- 255/1 then 13/15 back-to-back (second start in the done cycle) -> first result q=255 r=0; second result q=0 r=13, done 9 cycles after the second start.
- 37/0 -> done 1 cycle after the start edge; quotient=255, remainder=5, div_by_zero=1; a following 100/10 gives q=10 r=0 and clears div_by_zero.
- Start 200/7, pulse start with 50/3 at cycle 3 of RUN -> second request ignored; result q=28 r=4; busy stays 1 until done.
- Start 200/7, assert rst at cycle 4 -> all outputs 0 next cycle, no done pulse; new 9/2 then gives q=4 r=1.
- With DIV_SELFCHECK_EN, random 1000 divisions with non-zero divisors -> check_err never 1; force an internal R bit flip -> check_err=1 with done.
